// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared types for the iterative InvSubBytes stage: byte type, default
// state dimension, row-counter width helper and the FSM state encoding.
package inv_sub_bytes_iter_pkg;

    localparam int N_DEF = 4;

    typedef logic [7:0] byte_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } fsm_e;

    // Row counter is at least one bit wide even for a 1x1 state.
    function automatic int row_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/inv_sub_bytes_iter_if.sv
// State-transfer interface between upstream, the InvSubBytes stage and downstream.
interface inv_sub_bytes_iter_if #(parameter int N = 4);

    // A transfer happens on a rising clock edge where valid and ready are both
    // high; the sender holds valid and data stable until that edge.
    logic                      in_valid;
    logic                      in_ready;
    logic [N-1:0][N-1:0][7:0]  bytes_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [N-1:0][N-1:0][7:0]  bytes_out;

    modport master (
        output in_valid, bytes_in, out_ready,
        input  in_ready, out_valid, bytes_out
    );

    modport slave (
        input  in_valid, bytes_in, out_ready,
        output in_ready, out_valid, bytes_out
    );

endinterface

// File: rtl/inv_sub_bytes_iter_inv_sbox.sv
// FIPS-197 inverse S-box as a fully enumerated combinational lookup.
module inv_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] s_o
);

    always_comb begin
        case (a_i)
            8'h00: s_o = 8'h52; 8'h01: s_o = 8'h09; 8'h02: s_o = 8'h6a; 8'h03: s_o = 8'hd5; 8'h04: s_o = 8'h30; 8'h05: s_o = 8'h36; 8'h06: s_o = 8'ha5; 8'h07: s_o = 8'h38;
            8'h08: s_o = 8'hbf; 8'h09: s_o = 8'h40; 8'h0a: s_o = 8'ha3; 8'h0b: s_o = 8'h9e; 8'h0c: s_o = 8'h81; 8'h0d: s_o = 8'hf3; 8'h0e: s_o = 8'hd7; 8'h0f: s_o = 8'hfb;
            8'h10: s_o = 8'h7c; 8'h11: s_o = 8'he3; 8'h12: s_o = 8'h39; 8'h13: s_o = 8'h82; 8'h14: s_o = 8'h9b; 8'h15: s_o = 8'h2f; 8'h16: s_o = 8'hff; 8'h17: s_o = 8'h87;
            8'h18: s_o = 8'h34; 8'h19: s_o = 8'h8e; 8'h1a: s_o = 8'h43; 8'h1b: s_o = 8'h44; 8'h1c: s_o = 8'hc4; 8'h1d: s_o = 8'hde; 8'h1e: s_o = 8'he9; 8'h1f: s_o = 8'hcb;
            8'h20: s_o = 8'h54; 8'h21: s_o = 8'h7b; 8'h22: s_o = 8'h94; 8'h23: s_o = 8'h32; 8'h24: s_o = 8'ha6; 8'h25: s_o = 8'hc2; 8'h26: s_o = 8'h23; 8'h27: s_o = 8'h3d;
            8'h28: s_o = 8'hee; 8'h29: s_o = 8'h4c; 8'h2a: s_o = 8'h95; 8'h2b: s_o = 8'h0b; 8'h2c: s_o = 8'h42; 8'h2d: s_o = 8'hfa; 8'h2e: s_o = 8'hc3; 8'h2f: s_o = 8'h4e;
            8'h30: s_o = 8'h08; 8'h31: s_o = 8'h2e; 8'h32: s_o = 8'ha1; 8'h33: s_o = 8'h66; 8'h34: s_o = 8'h28; 8'h35: s_o = 8'hd9; 8'h36: s_o = 8'h24; 8'h37: s_o = 8'hb2;
            8'h38: s_o = 8'h76; 8'h39: s_o = 8'h5b; 8'h3a: s_o = 8'ha2; 8'h3b: s_o = 8'h49; 8'h3c: s_o = 8'h6d; 8'h3d: s_o = 8'h8b; 8'h3e: s_o = 8'hd1; 8'h3f: s_o = 8'h25;
            8'h40: s_o = 8'h72; 8'h41: s_o = 8'hf8; 8'h42: s_o = 8'hf6; 8'h43: s_o = 8'h64; 8'h44: s_o = 8'h86; 8'h45: s_o = 8'h68; 8'h46: s_o = 8'h98; 8'h47: s_o = 8'h16;
            8'h48: s_o = 8'hd4; 8'h49: s_o = 8'ha4; 8'h4a: s_o = 8'h5c; 8'h4b: s_o = 8'hcc; 8'h4c: s_o = 8'h5d; 8'h4d: s_o = 8'h65; 8'h4e: s_o = 8'hb6; 8'h4f: s_o = 8'h92;
            8'h50: s_o = 8'h6c; 8'h51: s_o = 8'h70; 8'h52: s_o = 8'h48; 8'h53: s_o = 8'h50; 8'h54: s_o = 8'hfd; 8'h55: s_o = 8'hed; 8'h56: s_o = 8'hb9; 8'h57: s_o = 8'hda;
            8'h58: s_o = 8'h5e; 8'h59: s_o = 8'h15; 8'h5a: s_o = 8'h46; 8'h5b: s_o = 8'h57; 8'h5c: s_o = 8'ha7; 8'h5d: s_o = 8'h8d; 8'h5e: s_o = 8'h9d; 8'h5f: s_o = 8'h84;
            8'h60: s_o = 8'h90; 8'h61: s_o = 8'hd8; 8'h62: s_o = 8'hab; 8'h63: s_o = 8'h00; 8'h64: s_o = 8'h8c; 8'h65: s_o = 8'hbc; 8'h66: s_o = 8'hd3; 8'h67: s_o = 8'h0a;
            8'h68: s_o = 8'hf7; 8'h69: s_o = 8'he4; 8'h6a: s_o = 8'h58; 8'h6b: s_o = 8'h05; 8'h6c: s_o = 8'hb8; 8'h6d: s_o = 8'hb3; 8'h6e: s_o = 8'h45; 8'h6f: s_o = 8'h06;
            8'h70: s_o = 8'hd0; 8'h71: s_o = 8'h2c; 8'h72: s_o = 8'h1e; 8'h73: s_o = 8'h8f; 8'h74: s_o = 8'hca; 8'h75: s_o = 8'h3f; 8'h76: s_o = 8'h0f; 8'h77: s_o = 8'h02;
            8'h78: s_o = 8'hc1; 8'h79: s_o = 8'haf; 8'h7a: s_o = 8'hbd; 8'h7b: s_o = 8'h03; 8'h7c: s_o = 8'h01; 8'h7d: s_o = 8'h13; 8'h7e: s_o = 8'h8a; 8'h7f: s_o = 8'h6b;
            8'h80: s_o = 8'h3a; 8'h81: s_o = 8'h91; 8'h82: s_o = 8'h11; 8'h83: s_o = 8'h41; 8'h84: s_o = 8'h4f; 8'h85: s_o = 8'h67; 8'h86: s_o = 8'hdc; 8'h87: s_o = 8'hea;
            8'h88: s_o = 8'h97; 8'h89: s_o = 8'hf2; 8'h8a: s_o = 8'hcf; 8'h8b: s_o = 8'hce; 8'h8c: s_o = 8'hf0; 8'h8d: s_o = 8'hb4; 8'h8e: s_o = 8'he6; 8'h8f: s_o = 8'h73;
            8'h90: s_o = 8'h96; 8'h91: s_o = 8'hac; 8'h92: s_o = 8'h74; 8'h93: s_o = 8'h22; 8'h94: s_o = 8'he7; 8'h95: s_o = 8'had; 8'h96: s_o = 8'h35; 8'h97: s_o = 8'h85;
            8'h98: s_o = 8'he2; 8'h99: s_o = 8'hf9; 8'h9a: s_o = 8'h37; 8'h9b: s_o = 8'he8; 8'h9c: s_o = 8'h1c; 8'h9d: s_o = 8'h75; 8'h9e: s_o = 8'hdf; 8'h9f: s_o = 8'h6e;
            8'ha0: s_o = 8'h47; 8'ha1: s_o = 8'hf1; 8'ha2: s_o = 8'h1a; 8'ha3: s_o = 8'h71; 8'ha4: s_o = 8'h1d; 8'ha5: s_o = 8'h29; 8'ha6: s_o = 8'hc5; 8'ha7: s_o = 8'h89;
            8'ha8: s_o = 8'h6f; 8'ha9: s_o = 8'hb7; 8'haa: s_o = 8'h62; 8'hab: s_o = 8'h0e; 8'hac: s_o = 8'haa; 8'had: s_o = 8'h18; 8'hae: s_o = 8'hbe; 8'haf: s_o = 8'h1b;
            8'hb0: s_o = 8'hfc; 8'hb1: s_o = 8'h56; 8'hb2: s_o = 8'h3e; 8'hb3: s_o = 8'h4b; 8'hb4: s_o = 8'hc6; 8'hb5: s_o = 8'hd2; 8'hb6: s_o = 8'h79; 8'hb7: s_o = 8'h20;
            8'hb8: s_o = 8'h9a; 8'hb9: s_o = 8'hdb; 8'hba: s_o = 8'hc0; 8'hbb: s_o = 8'hfe; 8'hbc: s_o = 8'h78; 8'hbd: s_o = 8'hcd; 8'hbe: s_o = 8'h5a; 8'hbf: s_o = 8'hf4;
            8'hc0: s_o = 8'h1f; 8'hc1: s_o = 8'hdd; 8'hc2: s_o = 8'ha8; 8'hc3: s_o = 8'h33; 8'hc4: s_o = 8'h88; 8'hc5: s_o = 8'h07; 8'hc6: s_o = 8'hc7; 8'hc7: s_o = 8'h31;
            8'hc8: s_o = 8'hb1; 8'hc9: s_o = 8'h12; 8'hca: s_o = 8'h10; 8'hcb: s_o = 8'h59; 8'hcc: s_o = 8'h27; 8'hcd: s_o = 8'h80; 8'hce: s_o = 8'hec; 8'hcf: s_o = 8'h5f;
            8'hd0: s_o = 8'h60; 8'hd1: s_o = 8'h51; 8'hd2: s_o = 8'h7f; 8'hd3: s_o = 8'ha9; 8'hd4: s_o = 8'h19; 8'hd5: s_o = 8'hb5; 8'hd6: s_o = 8'h4a; 8'hd7: s_o = 8'h0d;
            8'hd8: s_o = 8'h2d; 8'hd9: s_o = 8'he5; 8'hda: s_o = 8'h7a; 8'hdb: s_o = 8'h9f; 8'hdc: s_o = 8'h93; 8'hdd: s_o = 8'hc9; 8'hde: s_o = 8'h9c; 8'hdf: s_o = 8'hef;
            8'he0: s_o = 8'ha0; 8'he1: s_o = 8'he0; 8'he2: s_o = 8'h3b; 8'he3: s_o = 8'h4d; 8'he4: s_o = 8'hae; 8'he5: s_o = 8'h2a; 8'he6: s_o = 8'hf5; 8'he7: s_o = 8'hb0;
            8'he8: s_o = 8'hc8; 8'he9: s_o = 8'heb; 8'hea: s_o = 8'hbb; 8'heb: s_o = 8'h3c; 8'hec: s_o = 8'h83; 8'hed: s_o = 8'h53; 8'hee: s_o = 8'h99; 8'hef: s_o = 8'h61;
            8'hf0: s_o = 8'h17; 8'hf1: s_o = 8'h2b; 8'hf2: s_o = 8'h04; 8'hf3: s_o = 8'h7e; 8'hf4: s_o = 8'hba; 8'hf5: s_o = 8'h77; 8'hf6: s_o = 8'hd6; 8'hf7: s_o = 8'h26;
            8'hf8: s_o = 8'he1; 8'hf9: s_o = 8'h69; 8'hfa: s_o = 8'h14; 8'hfb: s_o = 8'h63; 8'hfc: s_o = 8'h55; 8'hfd: s_o = 8'h21; 8'hfe: s_o = 8'h0c; 8'hff: s_o = 8'h7d;
        endcase
    end

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: one row of the N x N state per cycle through N
// shared inverse S-box lanes, with valid/ready handshakes on both sides.
module inv_sub_bytes_iter
    import inv_sub_bytes_iter_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inv_sub_bytes_iter_if.slave  bus,
    output fsm_e                 dbg_state_o
);

    localparam int RW = row_w(N);

    fsm_e                      state_q, state_d;
    logic [RW-1:0]             row_q, row_d;
    logic [N-1:0][N-1:0][7:0]  work_q, work_d;
    logic [N-1:0][7:0]         sub_row;

    for (genvar c = 0; c < N; c++) begin : g_lane
        inv_sbox u_inv_sbox (
            .a_i (work_q[row_q][c]),
            .s_o (sub_row[c])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            row_q   <= '0;
            work_q  <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            work_q  <= work_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        work_d        = work_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    work_d  = bus.bytes_in;
                    row_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                work_d[row_q] = sub_row;
                if (row_q == RW'(N - 1)) begin
                    row_d   = '0;
                    state_d = DONE;
                end else begin
                    row_d = row_q + 1'b1;
                end
            end
            DONE: begin
                bus.out_valid = 1'b1;
                // Ready is combinational from out_ready so a new state can be
                // taken on the same edge the result leaves.
                bus.in_ready  = bus.out_ready;
                if (bus.out_ready) begin
                    if (bus.in_valid) begin
                        work_d  = bus.bytes_in;
                        row_d   = '0;
                        state_d = BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.bytes_out = work_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: fixed vectors, backpressure, back-to-back,
// reset abort and forward/inverse round trip against a GF(2^8) model.
module tb_inv_sub_bytes_iter;
  import inv_sub_bytes_iter_pkg::*;

  localparam int N = 4;
  localparam int W = N * N * 8;

  typedef logic [N-1:0][N-1:0][7:0] state_t;
  typedef logic [N-1:0][7:0]        row_t;

  typedef struct {
    string  name;
    state_t din;
    state_t dexp;
  } vec_t;

  logic clk;
  logic rst_n;
  fsm_e dbg_state;

  inv_sub_bytes_iter_if #(.N(N)) bif ();

  inv_sub_bytes_iter #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bif),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] fwd_tbl [256];
  logic [7:0] inv_tbl [256];
  logic [W-1:0] exp_q [$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] d = {b, b};
    return d[15-n -: 8];
  endfunction

  task automatic build_tables();
    logic [7:0] iv;
    for (int x = 0; x < 256; x++) begin
      iv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gf_mul(8'(x), 8'(y)) == 8'h01) iv = 8'(y);
      fwd_tbl[x] = iv ^ rotl(iv, 1) ^ rotl(iv, 2) ^ rotl(iv, 3) ^ rotl(iv, 4) ^ 8'h63;
    end
    for (int x = 0; x < 256; x++) inv_tbl[fwd_tbl[x]] = 8'(x);
  endtask

  function automatic state_t model_inv(input state_t s);
    state_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = inv_tbl[s[i][j]];
    return r;
  endfunction

  function automatic state_t model_fwd(input state_t s);
    state_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = fwd_tbl[s[i][j]];
    return r;
  endfunction

  function automatic state_t rand_state();
    state_t r;
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) r[i][j] = 8'($urandom_range(0, 255));
    return r;
  endfunction

  function automatic row_t mk_row(input logic [7:0] c0, input logic [7:0] c1,
                                  input logic [7:0] c2, input logic [7:0] c3);
    row_t r;
    r[0] = c0; r[1] = c1; r[2] = c2; r[3] = c3;
    return r;
  endfunction

  function automatic state_t mk_st(input row_t r0, input row_t r1, input row_t r2, input row_t r3);
    state_t s;
    s[0] = r0; s[1] = r1; s[2] = r2; s[3] = r3;
    return s;
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called at a negedge; returns at the negedge following the acceptance edge.
  task automatic accept(input state_t st, input string name);
    logic rd;
    bit   ok = 0;
    bif.in_valid = 1'b1;
    bif.bytes_in = st;
    for (int t = 0; t < 50 && !ok; t++) begin
      #1 rd = bif.in_ready;
      @(posedge clk);
      ok = rd;
      @(negedge clk);
    end
    bif.in_valid = 1'b0;
    check({name, " accept timeout"}, W'(ok), W'(1));
  endtask

  // Waits for out_valid with out_ready low, reads the result, then handshakes.
  task automatic get_out(output state_t st, output int lat);
    lat = 0;
    while (!bif.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    st = bif.bytes_out;
    bif.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bif.out_ready = 1'b0;
  endtask

  vec_t   vecs [4];
  state_t st, got, snap;
  int     lat, cnt;
  int     last_cyc, mon_cyc, n_got;

  initial begin
    rst_n         = 1'b0;
    bif.in_valid  = 1'b0;
    bif.bytes_in  = '0;
    bif.out_ready = 1'b0;
    build_tables();

    vecs[0] = '{"mixed",
                mk_st(mk_row(8'h00, 8'h01, 8'hff, 8'h16), mk_row(8'h63, 8'h7c, 8'hed, 8'h52),
                      mk_row(8'h63, 8'h7c, 8'hed, 8'h52), mk_row(8'h63, 8'h7c, 8'hed, 8'h52)),
                mk_st(mk_row(8'h52, 8'h09, 8'h7d, 8'hff), mk_row(8'h00, 8'h01, 8'h53, 8'h48),
                      mk_row(8'h00, 8'h01, 8'h53, 8'h48), mk_row(8'h00, 8'h01, 8'h53, 8'h48))};
    vecs[1] = '{"all_ff", {16{8'hff}}, {16{8'h7d}}};
    vecs[2] = '{"row_order",
                mk_st(mk_row(8'h63, 8'h63, 8'h63, 8'h63), mk_row(8'h00, 8'h00, 8'h00, 8'h00),
                      mk_row(8'h7c, 8'h7c, 8'h7c, 8'h7c), mk_row(8'h16, 8'h16, 8'h16, 8'h16)),
                mk_st(mk_row(8'h00, 8'h00, 8'h00, 8'h00), mk_row(8'h52, 8'h52, 8'h52, 8'h52),
                      mk_row(8'h01, 8'h01, 8'h01, 8'h01), mk_row(8'hff, 8'hff, 8'hff, 8'hff))};
    vecs[3] = '{"col_order",
                mk_st(mk_row(8'hed, 8'h52, 8'hff, 8'h01), mk_row(8'hed, 8'h52, 8'hff, 8'h01),
                      mk_row(8'hed, 8'h52, 8'hff, 8'h01), mk_row(8'hed, 8'h52, 8'hff, 8'h01)),
                mk_st(mk_row(8'h53, 8'h48, 8'h7d, 8'h09), mk_row(8'h53, 8'h48, 8'h7d, 8'h09),
                      mk_row(8'h53, 8'h48, 8'h7d, 8'h09), mk_row(8'h53, 8'h48, 8'h7d, 8'h09))};

    // Reset state
    do_reset();
    check("reset in_ready", W'(bif.in_ready), W'(1));
    check("reset out_valid", W'(bif.out_valid), W'(0));
    check("reset fsm", W'(dbg_state), W'(IDLE));
    check("reset bytes_out", W'(bif.bytes_out), W'(0));

    // Single transfer of all-63
    accept({16{8'h63}}, "single");
    get_out(got, lat);
    check("single latency", W'(lat), W'(N));
    check("single data", W'(got), W'(0));
    check("single back to idle", W'(dbg_state), W'(IDLE));

    // Fixed vector table
    for (int v = 0; v < 4; v++) begin
      accept(vecs[v].din, vecs[v].name);
      get_out(got, lat);
      check({vecs[v].name, " data"}, W'(got), W'(vecs[v].dexp));
      check({vecs[v].name, " latency"}, W'(lat), W'(N));
    end

    // Exhaustive byte coverage: 16 states carry every byte value once
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++) st[i][j] = 8'(k * 16 + i * N + j);
      accept(st, "sweep");
      get_out(got, lat);
      check("sweep data", W'(got), W'(model_inv(st)));
    end

    // Backpressure: hold DONE for 10 cycles
    st = rand_state();
    accept(st, "bp");
    lat = 0;
    while (!bif.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    snap = bif.bytes_out;
    check("bp data", W'(snap), W'(model_inv(st)));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp bytes_out stable", W'(bif.bytes_out), W'(snap));
      check("bp out_valid held", W'(bif.out_valid), W'(1));
      check("bp in_ready low", W'(bif.in_ready), W'(0));
    end
    bif.out_ready = 1'b1;
    #1 check("bp in_ready with out_ready", W'(bif.in_ready), W'(1));
    @(posedge clk);
    @(negedge clk);
    bif.out_ready = 1'b0;
    check("bp single handshake", W'(bif.out_valid), W'(0));
    check("bp idle after", W'(dbg_state), W'(IDLE));

    // Back-to-back with out_ready held high
    bif.out_ready = 1'b1;
    last_cyc = -1;
    mon_cyc  = 0;
    n_got    = 0;
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          logic rd;
          bit   ok;
          st = rand_state();
          exp_q.push_back(W'(model_inv(st)));
          bif.bytes_in = st;
          bif.in_valid = 1'b1;
          ok = 0;
          for (int t = 0; t < 50 && !ok; t++) begin
            #1 rd = bif.in_ready;
            @(posedge clk);
            ok = rd;
            @(negedge clk);
          end
          check("b2b accept timeout", W'(ok), W'(1));
        end
        bif.in_valid = 1'b0;
      end
      begin
        while (n_got < 8 && mon_cyc < 300) begin
          @(negedge clk);
          mon_cyc++;
          if (bif.out_valid) begin
            if (exp_q.size() == 0) begin
              check("b2b unexpected output", W'(1), W'(0));
            end else begin
              check("b2b data", W'(bif.bytes_out), exp_q.pop_front());
            end
            if (last_cyc >= 0) check("b2b spacing", W'(mon_cyc - last_cyc), W'(N + 1));
            last_cyc = mon_cyc;
            n_got++;
          end
        end
      end
    join
    check("b2b output count", W'(n_got), W'(8));
    @(negedge clk);
    check("b2b no extra output", W'(bif.out_valid), W'(0));
    bif.out_ready = 1'b0;
    exp_q.delete();

    // Reset in the middle of BUSY aborts the transfer
    accept(rand_state(), "abort");
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("abort out_valid in reset", W'(bif.out_valid), W'(0));
    check("abort in_ready in reset", W'(bif.in_ready), W'(1));
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bif.out_valid) cnt++;
    end
    check("abort no output", W'(cnt), W'(0));
    check("abort fsm idle", W'(dbg_state), W'(IDLE));

    // Round trip: forward S-box model then DUT returns the original
    for (int k = 0; k < 1000; k++) begin
      st = rand_state();
      accept(model_fwd(st), "roundtrip");
      get_out(got, lat);
      check("roundtrip data", W'(got), W'(st));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
Iterative InvSubBytes stage for the AES decryption datapath. It is the inverse of the forward byte-substitution stage.
- Accepts a full N x N row-major state through a valid/ready handshake.
- Substitutes one row per cycle through N shared inverse S-box lanes.
- Presents the result with a valid/ready output handshake.
- Sits between InvShiftRows and AddRoundKey in the round-sequenced decryption core.

Parameters:
N, 4, state dimension; state is N rows x N columns of bytes, row-major.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  bytes_in holds a valid state.
in_ready  output  1  block can accept a state this cycle.
bytes_in  input  [7:0] [N][N]  ciphertext-side state, row-major.
out_valid  output  1  bytes_out holds a completed substituted state.
out_ready  input  1  downstream accepts bytes_out this cycle.
bytes_out  output  [7:0] [N][N]  inverse-substituted state, row-major.

Behaviour:
- Reset (asynchronous on rst_n low):
  - state IDLE, row counter 0, working register all 8'h00.
  - out_valid 0, in_ready 1.
  - Reset mid-operation aborts the transfer with no output and no partial result.
- FSM has three states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load bytes_in into the working register, row counter <= 0, go to BUSY.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, replace working-register row[row counter] with inv_sbox of each byte in that row, all N lanes in parallel.
  - Increment the counter. After row N-1 completes, counter <= 0 and go to DONE.
- DONE:
  - out_valid=1.
  - bytes_out is stable and must not change until the handshake completes.
  - out_ready=1 completes the handshake. Then:
    - If in_valid is also high, load the new state and go to BUSY (back-to-back transfer).
    - Otherwise go to IDLE.
- in_ready = (IDLE) | (DONE & out_ready). This is combinational from out_ready, documented for the integrator.
- Latency:
  - Acceptance edge at t gives out_valid high after edge t+N (N=4 → 4 cycles).
  - Sustained throughput is one state per N+1 cycles with out_ready held high.
- bytes_out is driven directly from the working register:
  - Contents are defined only while out_valid=1.
  - Partially substituted values are visible during BUSY and must be ignored.
- in_valid with in_ready low: no effect. bytes_in is not sampled and the upstream holds it.
- out_ready while not DONE: ignored.
- inv_sbox is the FIPS-197 inverse S-box, combinational and fully enumerated (256 entries, no default path). Examples: 00→52, 01→09, 63→00, 7c→01, ff→7d, 16→ff.
- Arithmetic/width rules:
  - Row counter width is $clog2(N) with a minimum of 1. It wraps only by explicit reset to 0 at row N-1.
  - No arithmetic on data bytes; pure table lookup.
- Invariant (verification): the composition of forward sub-bytes followed by this block is the identity on any state.

Decomposition:
- Shared AES package (aes_pkg):
  - state byte typedef and state array typedef parameterised on N.
  - FSM state enum (IDLE/BUSY/DONE) local to this block, or in the package if the encrypt-side iterative stage reuses it.
- One sub-module: inv_sbox (8-bit combinational lookup), instantiated N times, one per column lane.
- Row selection mux/demux stays in the top module.

Test Plan:
- Reset/idle: assert rst_n=0 mid-BUSY, release → out_valid=0, in_ready=1, no output ever appears for the aborted state.
- Single transfer: all bytes 8'h63, out_ready=1 → out_valid rises exactly 4 cycles after acceptance; all bytes_out = 8'h00.
- Mixed lookups:
  - Row 0 = {00,01,ff,16} → {52,09,7d,ff}.
  - Rows 1-3 = {63,7c,ed,52} → {00,01,53,48}.
  - Check row ordering and column placement are preserved.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → bytes_out and out_valid stable and in_ready=0 throughout. Then pulse out_ready → single handshake, return to IDLE.
- Back-to-back: in_valid held with out_ready=1 and 8 distinct random states → each output equals the software inverse-S-box model, with spacing N+1 cycles and no drops or duplicates.
- Round trip: 1000 random states through forward sub-bytes then this block → output equals the original state.
